// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch resolver: queue entry layout,
// default sizing and a saturating increment.
package bp_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic valid;
    logic filled;
    logic pred;
  } entry_t;

  // Increments value, holding at max_value once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline/predictor-facing signal bundle of the branch resolver.
// The master side is the pipeline plus predictor; the slave side is the resolver.
interface branch_resolver_if #(
  parameter int CNT_W = 16
);

  logic             fetch_branch;
  logic             stall;
  logic             pred_request;
  logic             prediction;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             pred_result;
  logic             pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             proto_err;

  modport master (
    output fetch_branch, prediction, resolve_valid, resolve_taken,
    input  stall, pred_request, pred_result, pred_taken, mispredict,
           branch_count, mispredict_count, proto_err
  );

  modport slave (
    input  fetch_branch, prediction, resolve_valid, resolve_taken,
    output stall, pred_request, pred_result, pred_taken, mispredict,
           branch_count, mispredict_count, proto_err
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Statistics counter that increments on inc and sticks at its maximum value.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) value_d = CNT_W'(sat_inc(32'(value_q), MAX_VAL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/branch_resolver.sv
// Holds predictions for in-flight branches in order, checks them against
// resolved outcomes, trains the predictor and flushes on mispredict.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolver_if.slave   bus
);

  localparam int             PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

  entry_t           q_q [DEPTH];
  entry_t           q_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             fill_pend_q, fill_pend_d;
  logic [PTR_W-1:0] fill_idx_q, fill_idx_d;
  logic             pred_result_q, pred_taken_q, mispredict_q, proto_err_q;

  entry_t head;
  logic   stall, req, legal, miss, pop, flush;

  // Stall looks only at registered occupancy, so resolve never reaches it.
  assign stall = (occ_q == FULL);
  assign req   = bus.fetch_branch & ~stall;
  assign head  = q_q[rd_ptr_q];
  assign legal = bus.resolve_valid & head.valid & head.filled;
  assign miss  = legal & (bus.resolve_taken != head.pred);
  assign pop   = legal & ~miss;
  assign flush = legal & miss;

  // NOTE: every next-state variable gets a default first so no latch is
  // inferred; later blocking assignments in this block override earlier ones.
  always_comb begin
    q_d         = q_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    fill_pend_d = 1'b0;
    fill_idx_d  = fill_idx_q;

    if (fill_pend_q) begin
      q_d[fill_idx_q].pred   = bus.prediction;
      q_d[fill_idx_q].filled = 1'b1;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (pop) begin
        q_d[rd_ptr_q] = '0;
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      end
      if (req) begin
        q_d[wr_ptr_q] = '{valid: 1'b1, filled: 1'b0, pred: 1'b0};
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
        fill_pend_d   = 1'b1;
        fill_idx_d    = wr_ptr_q;
      end
      unique case ({req, pop})
        2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
        2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: the queue storage is reset too, because each entry carries its own
  // valid bit that legality checks depend on; non-blocking assigns only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      fill_pend_q   <= 1'b0;
      fill_idx_q    <= '0;
      pred_result_q <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      q_q           <= q_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      fill_pend_q   <= fill_pend_d;
      fill_idx_q    <= fill_idx_d;
      pred_result_q <= legal;
      pred_taken_q  <= legal & bus.resolve_taken;
      mispredict_q  <= miss;
      proto_err_q   <= proto_err_q | (bus.resolve_valid & ~legal);
    end
  end

  bp_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (legal),
    .value (bus.branch_count)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss),
    .value (bus.mispredict_count)
  );

  assign bus.stall        = stall;
  assign bus.pred_request = req;
  assign bus.pred_result  = pred_result_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: two instances (16-bit and 2-bit counters) share
// stimulus and are compared against a queue-of-predictions reference model.
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if #(.CNT_W(16)) bus_a ();
  branch_resolver_if #(.CNT_W(2))  bus_b ();

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  branch_resolver #(.DEPTH(DEPTH), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Model: one element per outstanding branch, -1 while its prediction is unknown.
  int mq[$];
  int n_bc, n_mc;
  bit exp_res, exp_tk, exp_mis, exp_proto;
  bit obs_stall, obs_req;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int satv(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fb, input bit pr, input bit rv, input bit rt);
    bus_a.fetch_branch = fb; bus_a.prediction = pr;
    bus_a.resolve_valid = rv; bus_a.resolve_taken = rt;
    bus_b.fetch_branch = fb; bus_b.prediction = pr;
    bus_b.resolve_valid = rv; bus_b.resolve_taken = rt;
  endtask

  task automatic check_regs();
    check("pred_result", 32'(bus_a.pred_result), 32'(exp_res));
    check("pred_taken", 32'(bus_a.pred_taken), 32'(exp_tk));
    check("mispredict", 32'(bus_a.mispredict), 32'(exp_mis));
    check("proto_err", 32'(bus_a.proto_err), 32'(exp_proto));
    check("branch_count", 32'(bus_a.branch_count), 32'(satv(n_bc, 16)));
    check("mispredict_count", 32'(bus_a.mispredict_count), 32'(satv(n_mc, 16)));
    check("branch_count_w2", 32'(bus_b.branch_count), 32'(satv(n_bc, 2)));
    check("mispredict_count_w2", 32'(bus_b.mispredict_count), 32'(satv(n_mc, 2)));
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input bit fb, input bit pr, input bit rv, input bit rt);
    bit full, req, legal, mis;
    drive(fb, pr, rv, rt);
    #1;
    full = (mq.size() == DEPTH);
    req  = fb && !full;
    check("stall", 32'(bus_a.stall), 32'(full));
    check("stall_w2", 32'(bus_b.stall), 32'(full));
    check("pred_request", 32'(bus_a.pred_request), 32'(req));
    obs_stall = bus_a.stall;
    obs_req   = bus_a.pred_request;

    legal = rv && (mq.size() > 0) && (mq[0] >= 0);
    mis   = legal && ((rt ? 1 : 0) != mq[0]);
    if (mq.size() > 0 && mq[mq.size()-1] < 0) mq[mq.size()-1] = pr ? 1 : 0;
    exp_res = legal;
    exp_tk  = legal && rt;
    exp_mis = mis;
    if (rv && !legal) exp_proto = 1'b1;
    if (legal) begin
      n_bc++;
      if (mis) begin
        n_mc++;
        mq.delete();
      end else begin
        void'(mq.pop_front());
      end
    end
    if (req && !mis) mq.push_back(-1);

    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic model_clear();
    mq.delete();
    n_bc = 0; n_mc = 0;
    exp_res = 0; exp_tk = 0; exp_mis = 0; exp_proto = 0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (mq.size() == 0) break;
      if (mq[0] >= 0) step(0, 1'($urandom_range(1)), 1, mq[0] == 1);
      else            step(0, 1'($urandom_range(1)), 0, 0);
    end
    check("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    int reqs;
    int saved_bc;
    bit rt;

    drive(0, 0, 0, 0);
    model_clear();
    #2;
    do_reset();
    check("reset_stall", 32'(bus_a.stall), 32'd0);
    check_regs();

    // One branch: request cycle 1, prediction cycle 2, resolve cycle 4.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    check("t1_pred_result", 32'(bus_a.pred_result), 32'd1);
    check("t1_pred_taken", 32'(bus_a.pred_taken), 32'd1);
    check("t1_mispredict", 32'(bus_a.mispredict), 32'd0);
    check("t1_branch_count", 32'(bus_a.branch_count), 32'd1);
    step(0, 0, 0, 0);
    check("t1_result_one_cycle", 32'(bus_a.pred_result), 32'd0);

    // Mispredict flush with three queued predictions of 1.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("t2_mispredict", 32'(bus_a.mispredict), 32'd1);
    check("t2_mispredict_count", 32'(bus_a.mispredict_count), 32'd1);
    step(1, 0, 0, 0);
    check("t2_stall_after_flush", 32'(obs_stall), 32'd0);
    check("t2_req_after_flush", 32'(obs_req), 32'd1);
    drain();

    // Fill the queue: six cycles of fetch, no resolves.
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1'($urandom_range(1)), 0, 0);
      reqs += obs_req ? 1 : 0;
      if (i == 4) check("t3_stall_cycle5", 32'(obs_stall), 32'd1);
    end
    check("t3_request_pulses", 32'(reqs), 32'd4);

    // Full queue: fetch and a correct resolve together.
    step(1, 0, 1, mq[0] == 1);
    check("t4_stall_at_pop", 32'(obs_stall), 32'd1);
    check("t4_req_at_pop", 32'(obs_req), 32'd0);
    step(0, 0, 0, 0);
    check("t4_stall_after_pop", 32'(obs_stall), 32'd0);
    step(1, 1, 0, 0);
    check("t4_refill_req", 32'(obs_req), 32'd1);
    step(0, 0, 0, 0);
    check("t4_full_again", 32'(obs_stall), 32'd1);
    drain();

    // Saturation: five correct resolves from reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
    end
    check("t5_count_w2_sat", 32'(bus_b.branch_count), 32'd3);
    check("t5_count_w16", 32'(bus_a.branch_count), 32'd5);

    // Protocol errors: empty queue, then unfilled head.
    saved_bc = int'(bus_a.branch_count);
    step(0, 0, 1, 0);
    check("t6_proto_empty", 32'(bus_a.proto_err), 32'd1);
    check("t6_no_result_empty", 32'(bus_a.pred_result), 32'd0);
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    check("t6_no_result_unfilled", 32'(bus_a.pred_result), 32'd0);
    check("t6_count_held", 32'(bus_a.branch_count), 32'(saved_bc));
    step(0, 0, 0, 0);
    check("t6_proto_sticky", 32'(bus_a.proto_err), 32'd1);
    drain();

    // Async reset dropped mid-cycle while a fill is pending.
    step(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_stall", 32'(bus_a.stall), 32'd0);
    check("t7_pred_request", 32'(bus_a.pred_request), 32'd1);
    check("t7_pred_result", 32'(bus_a.pred_result), 32'd0);
    check("t7_pred_taken", 32'(bus_a.pred_taken), 32'd0);
    check("t7_mispredict", 32'(bus_a.mispredict), 32'd0);
    check("t7_proto_err", 32'(bus_a.proto_err), 32'd0);
    check("t7_branch_count", 32'(bus_a.branch_count), 32'd0);
    check("t7_mispredict_count", 32'(bus_a.mispredict_count), 32'd0);
    check("t7_branch_count_w2", 32'(bus_b.branch_count), 32'd0);
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check_regs();

    // Randomized traffic, mostly correct resolves of a filled head.
    for (int c = 0; c < 400; c++) begin
      if (mq.size() > 0 && mq[0] >= 0 && $urandom_range(3) != 0) rt = (mq[0] == 1);
      else rt = 1'($urandom_range(1));
      step($urandom_range(9) < 6, 1'($urandom_range(1)), $urandom_range(9) < 4, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Fetch/execute-side partner of the 2-bit branch predictor. Issues prediction requests for fetched branches and holds each returned prediction in an in-order queue. When execute resolves a branch, it compares the outcome with the queued prediction, trains the predictor via its result/taken inputs, flags mispredicts and keeps statistics. It sits between the pipeline control and the predictor, driving exactly the predictor's request/result/taken inputs and consuming its prediction output.

## Interface
- DEPTH, 4: outstanding-branch queue entries (power of two, ≥2)
- CNT_W, 16: width of statistics counters

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_branch  in  1  fetch holds a branch needing a prediction
- stall  out  1  queue full; fetch must hold the branch
- pred_request  out  1  to predictor `request`; = fetch_branch & ~stall (combinational)
- prediction  in  1  from predictor; valid the cycle after pred_request was high
- resolve_valid  in  1  execute resolves oldest outstanding branch this cycle
- resolve_taken  in  1  actual outcome
- pred_result  out  1  to predictor `result` (registered pulse)
- pred_taken  out  1  to predictor `taken` (registered)
- mispredict  out  1  registered one-cycle pulse: outcome ≠ queued prediction
- branch_count  out  CNT_W  branches resolved, saturating
- mispredict_count  out  CNT_W  mispredicts, saturating
- proto_err  out  1  sticky: illegal resolve seen

## Operation
- Queue: DEPTH entries {valid, filled, pred}, write pointer, read pointer, occupancy count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Allocate: when pred_request is high, allocate an entry at the write pointer with valid=1, filled=0. A one-bit `fill_pend` plus a saved index are set.
- Fill: in the cycle after allocation (fill_pend=1), write `prediction` into the saved entry and set filled=1.
- Resolve (resolve_valid=1):
  - Legal only if the head entry is valid and filled. Otherwise set proto_err, and change no other state.
  - If legal, pop the head. Next cycle: pred_result=1, pred_taken=resolve_taken, mispredict=(resolve_taken ≠ head.pred). branch_count increments, and mispredict_count increments when mispredicting.
- Flush: a legal mispredicting resolve clears all remaining entries, clears fill_pend, and resets pointers and occupancy to 0. An allocation in the same cycle is discarded: no entry is created, but pred_request was still issued.
- Simultaneous allocate and legal non-mispredicting pop: occupancy is unchanged.
  - stall uses pre-pop occupancy (stall = occupancy==DEPTH), so no combinational path exists from resolve to stall.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset (rst_n low, any time, including mid-fill): queue empty, fill_pend=0, pointers=0. stall, pred_result, pred_taken, mispredict, proto_err=0; both counters=0. pred_request then follows fetch_branch.

## Timing
- Cycle N: fetch_branch=1, not full → pred_request=1; predictor samples it at edge N→N+1.
- Cycle N+1: prediction valid; captured at edge N+1→N+2. The earliest legal resolve of this branch is cycle N+2.
- Resolve in cycle M → pred_result/pred_taken/mispredict high in cycle M+1 only. The predictor updates its state at edge M+1→M+2.
- Back-to-back requests every cycle are sustained until full.
- Back-to-back resolves every cycle are sustained.

## Structure
- Shared package `bp_pkg`:
  - the queue-entry typedef {valid, filled, pred};
  - the default DEPTH and CNT_W constants;
  - a saturating-increment function.
- One sub-module, `bp_sat_counter` (CNT_W, inc, clk, rst_n → value). It is instantiated twice, for the branch and mispredict counters.
- The queue and control stay in `branch_resolver`.

## Test plan
- Reset then one branch:
  - fetch_branch pulse at cycle 1, prediction=1 at cycle 2, resolve_taken=1 at cycle 4.
  - Required: pred_result=1 and pred_taken=1 at cycle 5, mispredict=0, branch_count=1.
- Mispredict flush:
  - Queue 3 branches with predictions 1,1,1, then resolve the first with taken=0.
  - Required: mispredict pulse, mispredict_count=1, occupancy 0, and stall=0 with a new request accepted next cycle.
- Full/stall with DEPTH=4:
  - Hold fetch_branch for 6 cycles with no resolves.
  - Required: 4 pred_request pulses, stall=1 from cycle 5, then 0 the cycle after the first resolve.
- Simultaneous allocate and pop at full:
  - Queue is full; fetch_branch and a correct resolve occur together.
  - Required: stall still 1 that cycle, pred_request=0, and occupancy 3 afterwards.
- Protocol error:
  - resolve_valid with an empty queue, or one cycle after a request (unfilled head).
  - Required: proto_err=1 sticky, no pred_result, counters unchanged.
- Saturation and async reset:
  - With CNT_W=2, run 5 correct resolves → branch_count=3.
  - Then drop rst_n mid-cycle during a fill → all outputs 0 immediately.
